// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared widths, tag type and state encoding for the SDRAM port arbiter
//
// Purpose: constants and types used by sdram_port_arbiter and sdram_tag_fifo.
// Ports: none (package).
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 29;
    localparam int SDRAM_DATA_W = 64;
    localparam int SDRAM_BE_W   = 8;
    localparam int SDRAM_BC_W   = 8;

    // One outstanding read command: which master issued it and how many beats it returns.
    typedef struct packed {
        logic                  id;
        logic [SDRAM_BC_W-1:0] bc;
    } sdram_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_WBURST = 2'd2
    } arb_state_t;

    // A burstcount of zero is treated as a single beat.
    function automatic logic [SDRAM_BC_W-1:0] norm_bc(input logic [SDRAM_BC_W-1:0] bc);
        return (bc == '0) ? SDRAM_BC_W'(1) : bc;
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// rtl/sdram_tag_fifo.sv - synchronous FIFO of outstanding read tags
//
// Purpose: holds one sdram_tag_t per read command in flight at the slave.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   push, push_data       enqueue a tag
//   pop, pop_data         dequeue the head tag; pop_data is the current head
//   full, empty, count    occupancy status (all derived from registered state)
module sdram_tag_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  sdram_tag_t       push_data,
    input  logic             pop,
    output sdram_tag_t       pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sdram_tag_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-master round-robin arbiter for one Avalon-MM SDRAM port
//
// Purpose: shares one burst-capable SDRAM port between m0 and m1, holding the
// grant for whole write bursts, releasing after each read command, and routing
// read return beats to the issuing master via a tag FIFO.
// Ports:
//   clock, reset                    clock and synchronous active-high reset
//   m0_* / m1_*                     master-side Avalon-MM command, write and read-return signals
//   s_*                             slave-side Avalon-MM signals to the SDRAM controller
//   pending_count                   read commands issued but not fully returned
//   error                           sticky: read data returned with nothing pending
//   debug_value                     {grant, state, 0, pending_count, beat_cnt, 0}
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int MAX_PENDING = 8,
    parameter int PEND_W      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SDRAM_ADDR_W-1:0] m0_address,
    input  logic [SDRAM_BC_W-1:0]   m0_burstcount,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [SDRAM_DATA_W-1:0] m0_writedata,
    input  logic [SDRAM_BE_W-1:0]   m0_byteenable,
    output logic                    m0_waitrequest,
    output logic [SDRAM_DATA_W-1:0] m0_readdata,
    output logic                    m0_readdatavalid,
    input  logic [SDRAM_ADDR_W-1:0] m1_address,
    input  logic [SDRAM_BC_W-1:0]   m1_burstcount,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [SDRAM_DATA_W-1:0] m1_writedata,
    input  logic [SDRAM_BE_W-1:0]   m1_byteenable,
    output logic                    m1_waitrequest,
    output logic [SDRAM_DATA_W-1:0] m1_readdata,
    output logic                    m1_readdatavalid,
    output logic [SDRAM_ADDR_W-1:0] s_address,
    output logic [SDRAM_BC_W-1:0]   s_burstcount,
    output logic                    s_read,
    output logic                    s_write,
    output logic [SDRAM_DATA_W-1:0] s_writedata,
    output logic [SDRAM_BE_W-1:0]   s_byteenable,
    input  logic                    s_waitrequest,
    input  logic [SDRAM_DATA_W-1:0] s_readdata,
    input  logic                    s_readdatavalid,
    output logic [PEND_W-1:0]       pending_count,
    output logic                    error,
    output logic [31:0]             debug_value
);

    arb_state_t            state;
    logic                  grant;
    logic                  last_grant;
    logic [SDRAM_BC_W-1:0] beat_cnt;   // beats of the current write burst still to accept
    logic [SDRAM_BC_W-1:0] ret_cnt;    // beats already returned for the head tag

    logic                  active;
    logic                  g_read;
    logic                  g_write;
    logic [SDRAM_BC_W-1:0] g_bc;
    logic                  m0_elig;
    logic                  m1_elig;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  rdv_hit;
    logic                  last_ret;

    sdram_tag_t            push_tag;
    sdram_tag_t            head_tag;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign active  = (state != ST_IDLE);
    assign g_read  = grant ? m1_read  : m0_read;
    assign g_write = grant ? m1_write : m0_write;
    assign g_bc    = norm_bc(grant ? m1_burstcount : m0_burstcount);

    // Eligibility uses the registered full flag, so a pop in this cycle does not help.
    assign m0_elig = (m0_read || m0_write) && !(m0_read && fifo_full);
    assign m1_elig = (m1_read || m1_write) && !(m1_read && fifo_full);

    always_comb begin
        s_address    = '0;
        s_burstcount = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        if (active) begin
            s_address    = grant ? m1_address    : m0_address;
            s_burstcount = grant ? m1_burstcount : m0_burstcount;
            s_writedata  = grant ? m1_writedata  : m0_writedata;
            s_byteenable = grant ? m1_byteenable : m0_byteenable;
            // Reads only start from CMD; a read alongside a write wins.
            s_read       = (state == ST_CMD) && g_read;
            s_write      = (state == ST_CMD) ? (g_write && !g_read) : g_write;
        end
    end

    assign m0_waitrequest = (active && !grant) ? s_waitrequest : 1'b1;
    assign m1_waitrequest = (active &&  grant) ? s_waitrequest : 1'b1;

    assign rd_accept = s_read  && !s_waitrequest;
    assign wr_accept = s_write && !s_waitrequest;

    assign push_tag.id = grant;
    assign push_tag.bc = g_bc;

    sdram_tag_fifo #(
        .DEPTH (MAX_PENDING),
        .CNT_W (PEND_W)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rd_accept),
        .push_data (push_tag),
        .pop       (last_ret),
        .pop_data  (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending_count)
    );

    // Read return routing is zero-latency: the head tag names the owner of each beat.
    assign rdv_hit          = s_readdatavalid && !fifo_empty;
    assign last_ret         = rdv_hit && ((ret_cnt + 1'b1) == head_tag.bc);
    assign m0_readdatavalid = rdv_hit && !head_tag.id;
    assign m1_readdatavalid = rdv_hit &&  head_tag.id;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            ret_cnt <= '0;
            error   <= 1'b0;
        end else begin
            if (last_ret) begin
                ret_cnt <= '0;
            end else if (rdv_hit) begin
                ret_cnt <= ret_cnt + 1'b1;
            end
            if (s_readdatavalid && fifo_empty) begin
                error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_elig && m1_elig) begin
                        grant <= ~last_grant;
                        state <= ST_CMD;
                    end else if (m0_elig) begin
                        grant <= 1'b0;
                        state <= ST_CMD;
                    end else if (m1_elig) begin
                        grant <= 1'b1;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rd_accept) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end else if (wr_accept) begin
                        if (g_bc == SDRAM_BC_W'(1)) begin
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end else begin
                            beat_cnt <= g_bc - 1'b1;
                            state    <= ST_WBURST;
                        end
                    end else if (!g_read && !g_write) begin
                        // Master withdrew its request: release without touching fairness.
                        state <= ST_IDLE;
                    end
                end
                ST_WBURST: begin
                    if (!g_write) begin
                        beat_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (wr_accept) begin
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == SDRAM_BC_W'(1)) begin
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [1:0] grant_vec;
    assign grant_vec   = active ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign debug_value = {grant_vec, state, 4'b0, 8'(pending_count), beat_cnt, 8'b0};

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
    import sdram_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [28:0] m0_address, m1_address, s_address;
    logic [7:0]  m0_burstcount, m1_burstcount, s_burstcount;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [63:0] m0_writedata, m1_writedata, s_writedata;
    logic [7:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [63:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [3:0]  pending_count;
    logic        error;
    logic [31:0] debug_value;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    sdram_port_arbiter #(.MAX_PENDING(8), .PEND_W(4)) dut (
        .clock(clock), .reset(reset),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .pending_count(pending_count), .error(error), .debug_value(debug_value)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_address = '0; m0_burstcount = 8'd1; m0_read = 0; m0_write = 0;
        m0_writedata = '0; m0_byteenable = 8'hFF;
        m1_address = '0; m1_burstcount = 8'd1; m1_read = 0; m1_write = 0;
        m1_writedata = '0; m1_byteenable = 8'hFF;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        do_reset();
        check_eq("rst_s_read", s_read, 0);
        check_eq("rst_s_write", s_write, 0);
        check_eq("rst_s_address", s_address, 0);
        check_eq("rst_m0_wait", m0_waitrequest, 1);
        check_eq("rst_m1_wait", m1_waitrequest, 1);
        check_eq("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
        check_eq("rst_pending", pending_count, 0);
        check_eq("rst_error", error, 0);

        // 1: single-beat write from m0
        m0_write = 1; m0_burstcount = 8'd1; m0_address = 29'h0600_0000;
        m0_writedata = 64'hDEADBEEF_CAFEBABE;
        #1;
        check_eq("t1_latency_s_write", s_write, 0);
        tick();
        check_eq("t1_s_write", s_write, 1);
        check_eq("t1_s_address", s_address, 29'h0600_0000);
        check_eq("t1_s_writedata", s_writedata, 64'hDEADBEEF_CAFEBABE);
        check_eq("t1_m0_wait", m0_waitrequest, 0);
        check_eq("t1_m1_wait", m1_waitrequest, 1);
        tick();
        m0_write = 0;
        #1;
        check_eq("t1_s_write_after", s_write, 0);
        check_eq("t1_state_idle", debug_value[29:28], 0);

        // 2: simultaneous reads after reset, m0 first
        do_reset();
        m0_read = 1; m0_burstcount = 8'd1; m0_address = 29'h10;
        m1_read = 1; m1_burstcount = 8'd1; m1_address = 29'h20;
        #1;
        check_eq("t2_pending0", pending_count, 0);
        tick();
        check_eq("t2_first_read", s_read, 1);
        check_eq("t2_first_addr", s_address, 29'h10);
        check_eq("t2_first_m1_wait", m1_waitrequest, 1);
        tick();
        m0_read = 0;
        #1;
        check_eq("t2_pending1", pending_count, 1);
        check_eq("t2_idle_gap", s_read, 0);
        tick();
        check_eq("t2_second_addr", s_address, 29'h20);
        check_eq("t2_second_m1_wait", m1_waitrequest, 0);
        tick();
        m1_read = 0;
        #1;
        check_eq("t2_pending2", pending_count, 2);
        s_readdatavalid = 1; s_readdata = 64'h11;
        #1;
        check_eq("t2_ret1_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
        check_eq("t2_ret1_data", m0_readdata, 64'h11);
        tick();
        check_eq("t2_pending_after1", pending_count, 1);
        s_readdata = 64'h22;
        #1;
        check_eq("t2_ret2_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
        check_eq("t2_ret2_data", m1_readdata, 64'h22);
        tick();
        s_readdatavalid = 0;
        #1;
        check_eq("t2_pending_end", pending_count, 0);

        // 3: m1 bc=4 write with a 2-cycle stall on beat 2, m0 read waiting
        m1_write = 1; m1_burstcount = 8'd4; m1_address = 29'h300; m1_writedata = 64'hA0;
        tick();
        check_eq("t3_b1_data", s_writedata, 64'hA0);
        check_eq("t3_b1_m1_wait", m1_waitrequest, 0);
        m0_read = 1; m0_burstcount = 8'd1; m0_address = 29'h40;
        tick();
        m1_writedata = 64'hA1; s_waitrequest = 1;
        #1;
        check_eq("t3_stall_m1_wait", m1_waitrequest, 1);
        check_eq("t3_stall_m0_wait", m0_waitrequest, 1);
        tick();
        check_eq("t3_stall2_data", s_writedata, 64'hA1);
        check_eq("t3_stall2_s_write", s_write, 1);
        tick();
        s_waitrequest = 0;
        #1;
        check_eq("t3_b2_data", s_writedata, 64'hA1);
        check_eq("t3_b2_m1_wait", m1_waitrequest, 0);
        tick();
        m1_writedata = 64'hA2;
        #1;
        check_eq("t3_b3_data", s_writedata, 64'hA2);
        check_eq("t3_b3_m0_wait", m0_waitrequest, 1);
        tick();
        m1_writedata = 64'hA3;
        #1;
        check_eq("t3_b4_data", s_writedata, 64'hA3);
        check_eq("t3_b4_m0_wait", m0_waitrequest, 1);
        tick();
        m1_write = 0;
        #1;
        check_eq("t3_idle_s_write", s_write, 0);
        check_eq("t3_idle_m0_wait", m0_waitrequest, 1);
        tick();
        check_eq("t3_m0_granted", s_read, 1);
        check_eq("t3_m0_addr", s_address, 29'h40);
        check_eq("t3_m0_wait", m0_waitrequest, 0);
        tick();
        m0_read = 0;
        s_readdatavalid = 1;
        #1;
        check_eq("t3_m0_rdv", m0_readdatavalid, 1);
        tick();
        s_readdatavalid = 0;
        #1;
        check_eq("t3_pending_end", pending_count, 0);

        // 4: fill the tag FIFO with eight bc=2 reads from m1
        m1_read = 1; m1_burstcount = 8'd2;
        for (int i = 0; i < 8; i++) begin
            m1_address = 29'h100 + 29'(i);
            tick();
            tick();
        end
        check_eq("t4_pending_full", pending_count, 8);
        m1_address = 29'h108;
        tick();
        tick();
        check_eq("t4_stalled_s_read", s_read, 0);
        check_eq("t4_stalled_m1_wait", m1_waitrequest, 1);
        m0_write = 1; m0_burstcount = 8'd1; m0_address = 29'h200; m0_writedata = 64'h55;
        tick();
        check_eq("t4_m0_write_granted", s_write, 1);
        check_eq("t4_m0_write_wait", m0_waitrequest, 0);
        tick();
        m0_write = 0;
        s_readdatavalid = 1;
        #1;
        check_eq("t4_ret_to_m1", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
        tick();
        check_eq("t4_pending_mid", pending_count, 8);
        tick();
        s_readdatavalid = 0;
        #1;
        check_eq("t4_pending7", pending_count, 7);
        check_eq("t4_not_yet", s_read, 0);
        tick();
        check_eq("t4_ninth_read", s_read, 1);
        check_eq("t4_ninth_addr", s_address, 29'h108);
        tick();
        m1_read = 0;
        #1;
        check_eq("t4_pending_refull", pending_count, 8);
        s_readdatavalid = 1;
        repeat (16) tick();
        s_readdatavalid = 0;
        #1;
        check_eq("t4_drained", pending_count, 0);
        check_eq("t4_no_error", error, 0);

        // 5: return beat with nothing pending
        s_readdatavalid = 1;
        #1;
        check_eq("t5_no_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
        tick();
        s_readdatavalid = 0;
        #1;
        check_eq("t5_error_set", error, 1);
        tick();
        tick();
        check_eq("t5_error_sticky", error, 1);

        // 6: reset on beat 2 of a bc=4 write, with one read outstanding
        m1_read = 1; m1_burstcount = 8'd1; m1_address = 29'h77;
        tick();
        tick();
        m1_read = 0;
        m0_write = 1; m0_burstcount = 8'd4; m0_address = 29'h500; m0_writedata = 64'hB0;
        tick();
        tick();
        m0_writedata = 64'hB1;
        #1;
        check_eq("t6_pre_pending", pending_count, 1);
        check_eq("t6_pre_s_write", s_write, 1);
        reset = 1;
        tick();
        reset = 0;
        m0_write = 0;
        #1;
        check_eq("t6_s_write", s_write, 0);
        check_eq("t6_state", debug_value[29:28], 0);
        check_eq("t6_pending", pending_count, 0);
        check_eq("t6_wait", {m1_waitrequest, m0_waitrequest}, 2'b11);
        check_eq("t6_error_cleared", error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
